// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// The memory answers combinationally for the address presented in the same cycle.
interface instruction_fetch_if;
    logic [31:0] imemAddress;
    logic        imemRead;
    logic [31:0] imemReadData;
    logic        imemReady;

    modport master (
        output imemAddress,
        output imemRead,
        input  imemReadData,
        input  imemReady
    );

    modport slave (
        input  imemAddress,
        input  imemRead,
        output imemReadData,
        output imemReady
    );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID pipeline register: owns the PC, issues fetches and buffers a word while decode stalls.
// Optional FETCH_PERF_COUNTER_EN adds fetchCount/stallCount performance counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_INCREMENT = 32'd4,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pcWrite,
    input  logic                        ifIdWrite,
    input  logic                        branchTaken,
    input  logic [31:0]                 branchTarget,
    instruction_fetch_if.master         imem,
    output logic [31:0]                 programCounterOut,
    output logic [31:0]                 instruction,
`ifdef FETCH_PERF_COUNTER_EN
    output logic [31:0]                 fetchCount,
    output logic [31:0]                 stallCount,
`endif
    output logic                        fetchStall
);

    typedef enum logic {FETCH, HOLD} fetchState_t;

    fetchState_t state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] holdBuffer, holdBufferNext;
    logic [31:0] instructionNext;
    logic [31:0] programCounterOutNext;
    logic        realLoad;
    logic [31:0] pcPlus;

    assign pcPlus           = pc + PC_INCREMENT;
    assign imem.imemAddress = pc;
    assign imem.imemRead    = ~reset;
    assign fetchStall       = (state == HOLD) || ((state == FETCH) && !imem.imemReady);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= FETCH;
            pc                <= RESET_VECTOR;
            holdBuffer        <= '0;
            instruction       <= NOP_WORD;
            programCounterOut <= '0;
        end else begin
            state             <= stateNext;
            pc                <= pcNext;
            holdBuffer        <= holdBufferNext;
            instruction       <= instructionNext;
            programCounterOut <= programCounterOutNext;
        end
    end

    // A redirect overrides everything, including the stall controls and any word arriving this cycle.
    always_comb begin
        stateNext             = state;
        pcNext                = pc;
        holdBufferNext        = holdBuffer;
        instructionNext       = instruction;
        programCounterOutNext = programCounterOut;
        realLoad              = 1'b0;

        if (branchTaken) begin
            pcNext                = branchTarget;
            instructionNext       = NOP_WORD;
            programCounterOutNext = '0;
            holdBufferNext        = '0;
            stateNext             = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imemReady) begin
                        if (ifIdWrite) begin
                            instructionNext       = imem.imemReadData;
                            programCounterOutNext = pcPlus;
                            realLoad              = 1'b1;
                            if (pcWrite) begin
                                pcNext = pcPlus;
                            end
                        end else begin
                            holdBufferNext = imem.imemReadData;
                            stateNext      = HOLD;
                        end
                    end else if (ifIdWrite) begin
                        // Bubble so decode never sees the previous word twice.
                        instructionNext       = NOP_WORD;
                        programCounterOutNext = '0;
                    end
                end
                HOLD: begin
                    if (ifIdWrite) begin
                        instructionNext       = holdBuffer;
                        programCounterOutNext = pcPlus;
                        realLoad              = 1'b1;
                        stateNext             = FETCH;
                        if (pcWrite) begin
                            pcNext = pcPlus;
                        end
                    end
                end
                default: begin
                    stateNext = FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (realLoad) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (fetchStall) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: sequential fetch, memory wait, decode stall/HOLD,
// redirects, PC wraparound, async reset and (with FETCH_PERF_COUNTER_EN) the performance counters.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] programCounterOut;
    logic [31:0] instruction;
    logic        fetchStall;
    logic        echoMode;
    logic        memReady;
    logic [31:0] memData;
`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    int checks;
    int errors;

    instruction_fetch_if bus ();

    // Memory model: either returns its own address as data or a fixed word.
    assign bus.imemReady    = memReady;
    assign bus.imemReadData = echoMode ? bus.imemAddress : memData;

    instruction_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .pcWrite          (pcWrite),
        .ifIdWrite        (ifIdWrite),
        .branchTaken      (branchTaken),
        .branchTarget     (branchTarget),
        .imem             (bus.master),
        .programCounterOut(programCounterOut),
        .instruction      (instruction),
`ifdef FETCH_PERF_COUNTER_EN
        .fetchCount       (fetchCount),
        .stallCount       (stallCount),
`endif
        .fetchStall       (fetchStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] expInstr, input logic [31:0] expPcOut, input logic [31:0] expAddr);
        checkOutput({tag, "_instr"}, instruction, expInstr);
        checkOutput({tag, "_pcout"}, programCounterOut, expPcOut);
        checkOutput({tag, "_addr"}, bus.imemAddress, expAddr);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        pcWrite      = 1'b1;
        ifIdWrite    = 1'b1;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        echoMode     = 1'b1;
        memReady     = 1'b0;
        memData      = 32'h0;

        #2;
        checkOutput("rst_imemRead", {31'd0, bus.imemRead}, 32'd0);
        checkIfId("rst", 32'h0, 32'h0, 32'h0);

        applyStimulus();
        applyStimulus();
        memReady = 1'b1;
        reset    = 1'b0;
        #1;
        checkOutput("run_imemRead", {31'd0, bus.imemRead}, 32'd1);
        checkOutput("run_stall", {31'd0, fetchStall}, 32'd0);

        // Zero-wait sequential fetch.
        applyStimulus(); checkIfId("seq0", 32'h0, 32'h4, 32'h4);
        applyStimulus(); checkIfId("seq1", 32'h4, 32'h8, 32'h8);
        applyStimulus(); checkIfId("seq2", 32'h8, 32'hC, 32'hC);
        applyStimulus(); checkIfId("seq3", 32'hC, 32'h10, 32'h10);

        // Memory not ready for two cycles at pc=0x10.
        memReady = 1'b0;
        #1;
        checkOutput("wait_stall", {31'd0, fetchStall}, 32'd1);
        applyStimulus(); checkIfId("wait0", 32'h0, 32'h0, 32'h10);
        applyStimulus(); checkIfId("wait1", 32'h0, 32'h0, 32'h10);
        memReady = 1'b1;
        #1;
        checkOutput("wait_release_stall", {31'd0, fetchStall}, 32'd0);
        applyStimulus(); checkIfId("wait2", 32'h10, 32'h14, 32'h14);

        // Decode stall while memory delivers 0xDEADBEEF: word parks in HOLD.
        echoMode  = 1'b0;
        memData   = 32'hDEAD_BEEF;
        ifIdWrite = 1'b0;
        pcWrite   = 1'b0;
        applyStimulus();
        checkIfId("hold0", 32'h10, 32'h14, 32'h14);
        checkOutput("hold0_stall", {31'd0, fetchStall}, 32'd1);
        memReady = 1'b0;
        memData  = 32'h1111_2222;
        applyStimulus();
        checkIfId("hold1", 32'h10, 32'h14, 32'h14);
        ifIdWrite = 1'b1;
        pcWrite   = 1'b1;
        applyStimulus();
        checkIfId("hold_rel", 32'hDEAD_BEEF, 32'h18, 32'h18);
        checkOutput("hold_rel_stall", {31'd0, fetchStall}, 32'd1);

        // Redirect while in HOLD discards the buffered word.
        memReady  = 1'b1;
        memData   = 32'hCAFE_F00D;
        ifIdWrite = 1'b0;
        pcWrite   = 1'b0;
        applyStimulus();
        checkIfId("bhold0", 32'hDEAD_BEEF, 32'h18, 32'h18);
        branchTaken  = 1'b1;
        branchTarget = 32'h100;
        applyStimulus();
        checkIfId("bflush", 32'h0, 32'h0, 32'h100);
        branchTaken = 1'b0;
        ifIdWrite   = 1'b1;
        pcWrite     = 1'b1;
        echoMode    = 1'b1;
        #1;
        checkOutput("bflush_stall", {31'd0, fetchStall}, 32'd0);
        applyStimulus();
        checkIfId("bafter", 32'h100, 32'h104, 32'h104);

        // PC wraparound at the top of the address space.
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFFC;
        applyStimulus();
        checkIfId("wrapbr", 32'h0, 32'h0, 32'hFFFF_FFFC);
        branchTaken = 1'b0;
        applyStimulus();
        checkIfId("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0);

        // Unaligned target passes through untouched.
        branchTaken  = 1'b1;
        branchTarget = 32'h203;
        applyStimulus();
        checkIfId("unal_br", 32'h0, 32'h0, 32'h203);
        branchTaken = 1'b0;
        applyStimulus();
        checkIfId("unal", 32'h203, 32'h207, 32'h207);

        // Asynchronous reset mid-stream, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        checkIfId("async_rst", 32'h0, 32'h0, 32'h0);
        checkOutput("async_rst_imemRead", {31'd0, bus.imemRead}, 32'd0);

`ifdef FETCH_PERF_COUNTER_EN
        checkOutput("perf_rst_fetch", fetchCount, 32'd0);
        checkOutput("perf_rst_stall", stallCount, 32'd0);
        applyStimulus();
        reset    = 1'b0;
        memReady = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        memReady = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        memReady = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("perf_fetch", fetchCount, 32'd5);
        checkOutput("perf_stall", stallCount, 32'd3);
        checkIfId("perf_end", 32'h10, 32'h14, 32'h14);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage and IF/ID pipeline register, directly upstream of the decode stage.
- Owns the program counter and drives the instruction-memory request.
- Registers {instruction, PC+4} for decode; obeys decode's pcWrite/ifIdWrite stall outputs.
- Accepts branch/jump redirects from later stages, which flush the IF/ID register.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- PC_INCREMENT, 4: byte stride between sequential instructions.
- NOP_WORD, 32'h0000_0000: word inserted into IF/ID on flush or bubble; decodes to all-zero control.

Ports:
- clk  in  1  stage clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- pcWrite  in  1  from decode hazard unit; 0 freezes PC.
- ifIdWrite  in  1  from decode hazard unit; 0 freezes the IF/ID register.
- branchTaken  in  1  redirect request from a later stage.
- branchTarget  in  32  redirect address; valid when branchTaken=1.
- imemAddress  out  32  fetch address; equals the PC register.
- imemRead  out  1  fetch request strobe.
- imemReadData  in  32  instruction word; valid when imemReady=1.
- imemReady  in  1  memory returns data for the current imemAddress this cycle.
- programCounterOut  out  32  IF/ID: address of the fetched instruction plus PC_INCREMENT.
- instruction  out  32  IF/ID: fetched instruction word.
- fetchStall  out  1  high while in HOLD, or in FETCH with imemReady=0.

Behaviour:
- Reset (async, takes effect immediately):
  - pc=RESET_VECTOR, state=FETCH, instruction=NOP_WORD, programCounterOut=0, holdBuffer=0.
  - imemRead=0 while reset is asserted; 1 in every non-reset cycle.
- Registers: pc, state {FETCH, HOLD}, holdBuffer[31:0], IF/ID pair.
- imemAddress=pc combinationally; the memory must respond to the address of the same cycle.
- Priority per posedge: reset > branchTaken > stall > normal.
- branchTaken=1, any state:
  - pc<=branchTarget; IF/ID<={0, NOP_WORD}; state<=FETCH; holdBuffer discarded.
  - Any imemReady that cycle is ignored.
  - pcWrite and ifIdWrite are ignored that cycle.
- FETCH, imemReady=1, ifIdWrite=1:
  - IF/ID<={pc+PC_INCREMENT, imemReadData}.
  - If pcWrite=1, pc<=pc+PC_INCREMENT.
- FETCH, imemReady=1, ifIdWrite=0:
  - holdBuffer<=imemReadData; state<=HOLD; IF/ID and pc unchanged.
- FETCH, imemReady=0:
  - If ifIdWrite=1, IF/ID<={0, NOP_WORD} (bubble, so decode never re-executes a word); otherwise IF/ID holds.
  - pc unchanged.
- HOLD (no memory request consumed; imemReady ignored):
  - ifIdWrite=1: IF/ID<={pc+PC_INCREMENT, holdBuffer}; state<=FETCH; pc<=pc+PC_INCREMENT if pcWrite=1.
  - ifIdWrite=0: everything holds.
- Latency: 1 cycle from imemReady to IF/ID output with zero-wait memory, giving 1 instruction per cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0, and programCounterOut wraps the same way.
- branchTarget is not alignment-checked; the low two bits pass through.
- Reset asserted mid-HOLD discards holdBuffer.

Optional Feature:
- Macro: FETCH_PERF_COUNTER_EN.
- Defined:
  - Adds output ports fetchCount[31:0] and stallCount[31:0], both reset to 0 asynchronously and wrapping at 2^32.
  - fetchCount increments on each IF/ID load with a real (non-NOP-inserted) word.
  - stallCount increments each cycle fetchStall=1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then zero-wait memory returning address-as-data for 3 cycles, pcWrite=ifIdWrite=1 -> instruction=0,4,8 and programCounterOut=4,8,12 on successive cycles.
- imemReady low 2 cycles at pc=0x10 -> IF/ID shows NOP_WORD/0 for 2 cycles, fetchStall=1, pc stays 0x10; word delivered on the third cycle.
- imemReady=1 with data 0xDEAD_BEEF while ifIdWrite=pcWrite=0 for 2 cycles -> state HOLD, IF/ID unchanged; on release, instruction=0xDEAD_BEEF, pc advances by 4, and no memory re-read is needed.
- branchTaken=1, branchTarget=0x100 during HOLD with ifIdWrite=0 -> next cycle pc=0x100, instruction=NOP_WORD, buffered word never reaches IF/ID.
- pc=0xFFFF_FFFC with zero-wait memory -> programCounterOut=0, next imemAddress=0; reset asserted mid-stream -> outputs reset without a clock edge.
- With FETCH_PERF_COUNTER_EN: 5 fetches and 3 stall cycles -> fetchCount=5, stallCount=3; build without the macro compiles with no counter ports.
